// File: rtl/matrix_mul_nxn_seq.sv
// Sequential NxN matrix multiplier: one MAC per cycle through a single shared multiplier.
// Latency: done and c_flat update N^3 cycles after the start edge; one job per N^3+1 cycles.
// Backpressure: start is honoured only when idle; it is dropped while busy, never queued.
module matrix_mul_nxn_seq #(
    parameter int N     = 2,
    parameter int DW    = 8,
    parameter int ACC_W = 2*DW + $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [N*N*DW-1:0]    a_flat,
    input  logic [N*N*DW-1:0]    b_flat,
    output logic [N*N*ACC_W-1:0] c_flat,
    output logic                 busy,
    output logic                 done
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int MW = N*N*DW;
    localparam int CW = N*N*ACC_W;
    localparam logic [IW-1:0] LAST = IW'(N-1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   a_q, a_d, b_q, b_d;
    logic            sm_q, sm_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [IW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
    logic [CW-1:0]   res_q, res_d, c_q, c_d;
    logic            busy_q, busy_d, done_q, done_d;

    logic [DW-1:0]           a_el, b_el;
    logic signed [DW:0]      a_x, b_x;
    logic signed [2*DW+1:0]  prod_full;
    logic [2*DW-1:0]         prod;
    logic signed [2*DW-1:0]  prod_s;
    logic [ACC_W-1:0]        prod_ext, sum;

    // Datapath: select A[i][k], B[k][j]; extend by one bit so a single signed multiply serves both modes
    always_comb begin
        a_el      = a_q[(int'(i_q)*N + int'(k_q))*DW +: DW];
        b_el      = b_q[(int'(k_q)*N + int'(j_q))*DW +: DW];
        a_x       = {sm_q & a_el[DW-1], a_el};
        b_x       = {sm_q & b_el[DW-1], b_el};
        prod_full = (2*DW+2)'(a_x) * (2*DW+2)'(b_x);
        prod      = prod_full[2*DW-1:0];
        prod_s    = prod_full[2*DW-1:0];
        if (sm_q) begin
            prod_ext = ACC_W'(prod_s);
        end else begin
            prod_ext = ACC_W'(prod);
        end
        sum = acc_q + prod_ext;
    end

    // Control: snapshot operands on start, walk k/j/i, publish the whole buffer on the last product
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sm_d    = sm_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        res_d   = res_q;
        c_d     = c_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_flat;
                    b_d     = b_flat;
                    sm_d    = signed_mode;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (k_q == LAST) begin
                    res_d[(int'(i_q)*N + int'(j_q))*ACC_W +: ACC_W] = sum;
                    acc_d = '0;
                    k_d   = '0;
                    if (j_q == LAST) begin
                        j_d = '0;
                        if (i_q == LAST) begin
                            i_d     = '0;
                            c_d     = res_d;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            i_d = i_q + IW'(1);
                        end
                    end else begin
                        j_d = j_q + IW'(1);
                    end
                end else begin
                    acc_d = sum;
                    k_d   = k_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any job and clears the published result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            res_q   <= '0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sm_q    <= sm_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            res_q   <= res_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign c_flat = c_q;
    assign busy   = busy_q;
    assign done   = done_q;
endmodule

// File: tb/tb_matrix_mul_nxn_seq.sv
// Bench for matrix_mul_nxn_seq: a 2x2/8-bit instance and a 3x3/4-bit instance.
// Expected results and completion cycles are queued at start; monitors compare on done.
// Runs a fixed directed sequence and ends with a single summary line.
module tb_matrix_mul_nxn_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    // 2x2, DW=8, ACC_W=17
    logic        s2, sm2, busy2, done2;
    logic [31:0] a2, b2;
    logic [67:0] c2;
    // 3x3, DW=4, ACC_W=10
    logic        s3, sm3, busy3, done3;
    logic [35:0] a3, b3;
    logic [89:0] c3;

    matrix_mul_nxn_seq #(.N(2), .DW(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(s2), .signed_mode(sm2),
        .a_flat(a2), .b_flat(b2), .c_flat(c2), .busy(busy2), .done(done2)
    );
    matrix_mul_nxn_seq #(.N(3), .DW(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(s3), .signed_mode(sm3),
        .a_flat(a3), .b_flat(b3), .c_flat(c3), .busy(busy3), .done(done3)
    );

    logic [67:0] exp_c2_q[$];
    int          exp_t2_q[$];
    logic [89:0] exp_c3_q[$];
    int          exp_t3_q[$];
    logic [67:0] last_c2, m_c2;
    logic [89:0] last_c3, m_c3;
    int          m_t2, m_t3;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    function automatic logic [31:0] pk2(input int e0, input int e1, input int e2, input int e3);
        logic [31:0] r;
        r[7:0] = 8'(e0); r[15:8] = 8'(e1); r[23:16] = 8'(e2); r[31:24] = 8'(e3);
        return r;
    endfunction

    function automatic logic [67:0] pc2(input int e0, input int e1, input int e2, input int e3);
        logic [67:0] r;
        r[16:0] = 17'(e0); r[33:17] = 17'(e1); r[50:34] = 17'(e2); r[67:51] = 17'(e3);
        return r;
    endfunction

    // Caller is positioned at a negedge; start is sampled on the following posedge.
    task automatic go2(input logic [31:0] a, input logic [31:0] b, input logic sm,
                       input logic [67:0] ec, input bit push);
        a2 = a; b2 = b; sm2 = sm; s2 = 1'b1;
        @(posedge clk); #1;
        s2 = 1'b0;
        if (push) begin
            exp_c2_q.push_back(ec);
            exp_t2_q.push_back(cyc + 8);
        end
        chk("busy_after_start2", busy2, 1);
    endtask

    task automatic wdone2(input string name);
        bit seen = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (done2) begin seen = 1; break; end
        end
        if (!seen) fail_now(name);
    endtask

    // Scoreboard monitor for the 2x2 instance, plus c_flat stability between completions
    always @(negedge clk) begin
        if (!rst_n) begin
            last_c2 = '0;
        end else if (done2) begin
            if (exp_c2_q.size() == 0) begin
                fail_now("unexpected_done2");
            end else begin
                m_c2 = exp_c2_q.pop_front();
                m_t2 = exp_t2_q.pop_front();
                chk("c_flat2", c2, m_c2);
                chk("done_cycle2", cyc, m_t2);
                chk("busy_at_done2", busy2, 0);
            end
            last_c2 = c2;
        end else if (c2 !== last_c2) begin
            chk("c_flat2_stable", c2, last_c2);
            last_c2 = c2;
        end
    end

    // Scoreboard monitor for the 3x3 instance
    always @(negedge clk) begin
        if (!rst_n) begin
            last_c3 = '0;
        end else if (done3) begin
            if (exp_c3_q.size() == 0) begin
                fail_now("unexpected_done3");
            end else begin
                m_c3 = exp_c3_q.pop_front();
                m_t3 = exp_t3_q.pop_front();
                chk("c_flat3", c3, m_c3);
                chk("done_cycle3", cyc, m_t3);
                chk("busy_at_done3", busy3, 0);
            end
            last_c3 = c3;
        end else if (c3 !== last_c3) begin
            chk("c_flat3_stable", c3, last_c3);
            last_c3 = c3;
        end
    end

    initial begin
        logic [35:0] ia, ib;
        logic [89:0] ic;
        bit seen3;

        rst_n = 1'b0;
        s2 = 0; sm2 = 0; a2 = '0; b2 = '0;
        s3 = 0; sm3 = 0; a3 = '0; b3 = '0;
        repeat (3) @(negedge clk);
        chk("reset_c2", c2, 0);
        chk("reset_busy2", busy2, 0);
        chk("reset_done2", done2, 0);
        chk("reset_c3", c3, 0);
        chk("reset_busy3", busy3, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Unsigned basic: [1 2;3 4]*[5 6;7 8] = [19 22;43 50]
        go2(pk2(1, 2, 3, 4), pk2(5, 6, 7, 8), 1'b0, pc2(19, 22, 43, 50), 1);
        wdone2("timeout_basic");
        @(negedge clk);

        // Unsigned max: every element 255*255*2 = 130050
        go2(pk2(255, 255, 255, 255), pk2(255, 255, 255, 255), 1'b0,
            pc2(130050, 130050, 130050, 130050), 1);
        wdone2("timeout_max");
        @(negedge clk);

        // Signed: [-1 2;3 -4]*[5 -6;7 8] = [9 22;-13 -50]
        go2(pk2(-1, 2, 3, -4), pk2(5, -6, 7, 8), 1'b1, pc2(9, 22, -13, -50), 1);
        wdone2("timeout_signed");
        @(negedge clk);

        // Start during a job is ignored; operand changes mid-job have no effect
        go2(pk2(1, 2, 3, 4), pk2(5, 6, 7, 8), 1'b0, pc2(19, 22, 43, 50), 1);
        @(negedge clk); @(negedge clk);
        a2 = '0; sm2 = 1'b1; s2 = 1'b1;
        @(posedge clk); #1;
        s2 = 1'b0;
        chk("busy_ignored_start2", busy2, 1);
        wdone2("timeout_ignored");
        // Back-to-back: start on the edge right after done
        go2(pk2(2, 0, 0, 2), pk2(1, 2, 3, 4), 1'b0, pc2(2, 4, 6, 8), 1);
        wdone2("timeout_b2b");
        @(negedge clk);

        // Reset at cycle 5 of a job: aborts with no done and clears c_flat
        go2(pk2(1, 2, 3, 4), pk2(5, 6, 7, 8), 1'b0, '0, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_c2", c2, 0);
        chk("midreset_busy2", busy2, 0);
        chk("midreset_done2", done2, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_reset_idle_busy2", busy2, 0);
        // Fresh signed job after reset: [-2 -3;1 0]*[-4 5;6 -7] = [-10 11;-4 5]
        go2(pk2(-2, -3, 1, 0), pk2(-4, 5, 6, -7), 1'b1, pc2(-10, 11, -4, 5), 1);
        wdone2("timeout_post_reset");
        @(negedge clk);

        // 3x3, DW=4: identity * [1..9] = [1..9]
        ia = '0; ib = '0; ic = '0;
        for (int v = 1; v <= 9; v++) begin
            ib[(v-1)*4 +: 4]  = 4'(v);
            ic[(v-1)*10 +: 10] = 10'(v);
        end
        for (int d = 0; d < 3; d++) ia[(d*3+d)*4 +: 4] = 4'd1;
        a3 = ia; b3 = ib; sm3 = 1'b0; s3 = 1'b1;
        @(posedge clk); #1;
        s3 = 1'b0;
        exp_c3_q.push_back(ic);
        exp_t3_q.push_back(cyc + 27);
        chk("busy_after_start3", busy3, 1);
        seen3 = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (done3) begin seen3 = 1; break; end
        end
        if (!seen3) fail_now("timeout_n3");

        repeat (4) @(negedge clk);
        chk("queue2_empty", exp_c2_q.size(), 0);
        chk("queue3_empty", exp_c3_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/matrix_mul_nxn_seq.md
# matrix_mul_nxn_seq

Parametrised sequential N×N matrix multiplier: one multiply-accumulate per clock, reusing a single multiplier across all N³ products. Successor to the fixed 2×2 sequential multiplier, with configurable dimension and element width and a per-job signed or unsigned mode. Operands are snapshotted at start, and results are published atomically. It sits between the operand register file and the result consumer, using a start/busy/done handshake.

## Interface
- N, default 2: matrix dimension, N ≥ 1.
- DW, default 8: operand element width in bits.
- ACC_W, default 2*DW+$clog2(N): result element width. Must not be overridden smaller than the default, which guarantees no overflow.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  job request; sampled only in IDLE.
- signed_mode  in  1  1 selects two's-complement operands, 0 selects unsigned; sampled with start.
- a_flat  in  N*N*DW  matrix A; element (r,c) at bits [(r*N+c)*DW +: DW].
- b_flat  in  N*N*DW  matrix B; same packing as A.
- c_flat  out  N*N*ACC_W  result C = A·B; element (r,c) at bits [(r*N+c)*ACC_W +: ACC_W].
- busy  out  1  high while a job is in progress.
- done  out  1  single-cycle pulse when c_flat is updated.

## Operation
- States:
  - IDLE: the only state that accepts start.
  - RUN: computes the products.
- Start acceptance: in IDLE, start=1 at an edge does the following:
  - latches a_flat, b_flat and signed_mode into internal copies;
  - clears the accumulator;
  - sets indices i=j=k=0;
  - moves to RUN and sets busy=1.
- RUN loop: each edge computes prod = A[i][k]*B[k][j] in 2*DW bits.
  - Signed mode: prod is a signed product. Unsigned mode: prod is an unsigned product.
  - prod is sign- or zero-extended to ACC_W.
  - For k<N-1, prod is added to the accumulator.
  - For k=N-1, acc+prod is written to internal result buffer entry (i,j) and the accumulator is cleared.
- Index order: k innermost, then j, then i outermost. k wraps N-1→0 and increments j. j wraps N-1→0 and increments i.
- Final product (i=j=k=N-1), on the same edge:
  - the whole result buffer, including the final entry, is copied into c_flat;
  - done=1, busy=0;
  - state returns to IDLE.
- Output stability: c_flat changes only at completion and holds its value until the next completion. A partially computed job is never visible on c_flat.
- Ignored inputs:
  - start while busy=1 is ignored; no queuing.
  - Changes to a_flat, b_flat or signed_mode during RUN do not affect the job in progress.
- N=1: the job takes a single RUN cycle; k, j and i wrap simultaneously.

## Timing
- Reset values: c_flat=0, busy=0, done=0, state=IDLE, accumulator and indices 0.
- Reset is asynchronous and may occur at any point. Asserting it mid-job aborts the job immediately: the outputs take their reset values, no done pulse is produced, and c_flat is cleared.
- Latency: with start sampled at edge E0, busy is high after E0. done and the new c_flat appear after edge E0+N³, and busy falls on that same edge. N=2 gives 8 cycles; N=3 gives 27.
- done is high for exactly one cycle. It never coincides with busy=1, except when a back-to-back start raises busy on the edge that drops done.
- Back-to-back jobs: start=1 on the edge following completion (E0+N³+1) is accepted. Throughput is one job per N³+1 cycles.
- Multiplier and adder are a single combinational stage per cycle; there is no internal pipelining.

## Test plan
- N=2, DW=8, unsigned; A=[1 2;3 4], B=[5 6;7 8] -> C=[19 22;43 50]; done exactly 8 cycles after the start edge; busy high for those 8 cycles.
- N=2, unsigned; all elements 255 -> every C element 130050 (0x1FC02), which fits ACC_W=17 without wrap.
- N=2, signed_mode=1; A=[-1 2;3 -4], B=[5 -6;7 8] -> C=[9 22;-13 -50], with sign-correct 17-bit values (e.g. -50 = 0x1FFCE).
- N=2; pulse start again and change a_flat to all zeros at cycle 3 of a job -> the second start is ignored, and the result matches the original operands with a single done pulse. Then assert start on the edge after done -> a second job starts immediately and completes 8 cycles later.
- N=2; assert rst_n low at cycle 5 of a job -> c_flat=0, busy=0, no done pulse. After release, a new job produces the correct result.
- N=3, DW=4, unsigned; A=identity, B=[1..9] row-major -> C=B; done 27 cycles after start.
